// File: rtl/stein_gcd_engine.sv
// -----------------------------------------------------------------------------
// stein_gcd_engine
//
// Binary-GCD (Stein) coprocessor. It accepts two WIDTH-bit unsigned operands
// over a valid/ready input channel and performs one shift or subtract step per
// clock. The result is returned over a valid/ready output channel and is held
// while the consumer applies backpressure. Only one job is in flight at a time.
//
// Flow: IDLE -> STRIP (remove common factors of two, counting them in k)
//            -> ODD_A (make a odd) -> REDUCE (shift/subtract until b == 0)
//            -> FINISH (restore 2^k) -> DONE (present result) -> IDLE.
//       If either operand is zero, the engine skips straight from IDLE to DONE.
//
// Optional build macro:
//   GCD_CYCLE_COUNT_EN  adds the out_cycles[15:0] port. It reports the number
//                       of STRIP/ODD_A/REDUCE/FINISH cycles for the job and
//                       saturates at 16'hFFFF.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   in_valid   operand pair valid
//   in_ready   engine can accept operands (IDLE only)
//   in_a       operand A, unsigned
//   in_b       operand B, unsigned
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   out_gcd    GCD result, registered
//   busy       computation in progress (not IDLE and not DONE)
//   out_cycles (GCD_CYCLE_COUNT_EN only) step count for the current result
// -----------------------------------------------------------------------------
module stein_gcd_engine #(
   parameter  int WIDTH = 32,
   localparam int KW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gcd,
   output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
   ,
   output logic [15:0]      out_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STRIP,
      S_ODD_A,
      S_REDUCE,
      S_FINISH,
      S_DONE
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] a, a_d;
   logic [WIDTH-1:0] b, b_d;
   logic [KW-1:0]    k, k_d;
   logic [WIDTH-1:0] gcd_d;
   logic             accept;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign accept    = in_valid && in_ready;

   // Next-state and datapath. Every step of the algorithm is a single
   // register update, so the whole step is computed here and committed below.
   // NOTE: every signal gets a default before the case statement; without it,
   // branches that leave a signal unassigned would infer a latch.
   always_comb begin
      state_d = state;
      a_d     = a;
      b_d     = b;
      k_d     = k;
      gcd_d   = out_gcd;

      case (state)
         S_IDLE: begin
            if (accept) begin
               a_d = in_a;
               b_d = in_b;
               k_d = '0;
               // gcd(0, x) = x and gcd(x, 0) = x; gcd(0, 0) falls out as 0.
               if (in_a == '0) begin
                  gcd_d   = in_b;
                  state_d = S_DONE;
               end else if (in_b == '0) begin
                  gcd_d   = in_a;
                  state_d = S_DONE;
               end else begin
                  state_d = S_STRIP;
               end
            end
         end

         S_STRIP: begin
            // Both even: the factor of two is common, so remember it in k.
            if (!a[0] && !b[0]) begin
               a_d = a >> 1;
               b_d = b >> 1;
               k_d = k + 1'b1;
            end else begin
               state_d = S_ODD_A;
            end
         end

         S_ODD_A: begin
            // b is odd here (or a already was), so factors of two in a alone
            // are not part of the GCD.
            if (!a[0]) begin
               a_d = a >> 1;
            end else begin
               state_d = S_REDUCE;
            end
         end

         S_REDUCE: begin
            // a stays odd throughout. The swap keeps a <= b, so the
            // subtraction below never underflows.
            if (b == '0) begin
               state_d = S_FINISH;
            end else if (!b[0]) begin
               b_d = b >> 1;
            end else if (a > b) begin
               a_d = b;
               b_d = a - b;
            end else begin
               b_d = b - a;
            end
         end

         S_FINISH: begin
            // k <= WIDTH-1 and the odd part fits the operands, so no bits
            // are lost in the shift.
            gcd_d   = a << k;
            state_d = S_DONE;
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         a       <= '0;
         b       <= '0;
         k       <= '0;
         out_gcd <= '0;
      end else begin
         state   <= state_d;
         a       <= a_d;
         b       <= b_d;
         k       <= k_d;
         out_gcd <= gcd_d;
      end
   end

`ifdef GCD_CYCLE_COUNT_EN
   logic [15:0] cycles_d;

   // Cleared on accept, so zero-operand shortcuts report 0. Counts only the
   // working states and stops at all-ones instead of wrapping.
   always_comb begin
      cycles_d = out_cycles;
      if (accept) begin
         cycles_d = '0;
      end else if ((state == S_STRIP || state == S_ODD_A ||
                    state == S_REDUCE || state == S_FINISH) &&
                   (out_cycles != 16'hFFFF)) begin
         cycles_d = out_cycles + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_cycles <= '0;
      end else begin
         out_cycles <= cycles_d;
      end
   end
`endif

endmodule
